// File: rtl/alu_cmd_sequencer_if.sv
// Command, response and ALU-side signal bundle for alu_cmd_sequencer.
// slave is the sequencer's view; master is the view of whatever drives it.
interface alu_cmd_sequencer_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_sel;
  logic [7:0]    cmd_a;
  logic [7:0]    cmd_b;
  logic          cmd_acc;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [7:0]    rsp_data;
  logic          rsp_carry;
  logic          rsp_zero;
  logic          acc_clr;
  logic [7:0]    acc_out;
  logic [7:0]    alu_a;
  logic [7:0]    alu_b;
  logic [2:0]    alu_sel;
  logic [7:0]    alu_res;
  logic          alu_cy;
  logic          busy;
  logic [CW-1:0] cmd_count;

  modport slave (
    input  cmd_valid, cmd_sel, cmd_a, cmd_b, cmd_acc, rsp_ready, acc_clr, alu_res, alu_cy,
    output cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_zero, acc_out, alu_a, alu_b,
           alu_sel, busy, cmd_count
  );

  modport master (
    output cmd_valid, cmd_sel, cmd_a, cmd_b, cmd_acc, rsp_ready, acc_clr, alu_res, alu_cy,
    input  cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_zero, acc_out, alu_a, alu_b,
           alu_sel, busy, cmd_count
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands in a FIFO, issues them one at a time through registered operands,
// captures result/flags into a valid/ready response and keeps a chaining accumulator.
module alu_cmd_sequencer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input logic                clk,
  input logic                rst_n,
  alu_cmd_sequencer_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  typedef struct packed {
    logic [2:0] sel;
    logic [7:0] a;
    logic [7:0] b;
    logic       acc;
  } cmd_t;

  state_e        state_q, state_d;
  cmd_t          fifo_q [DEPTH];
  cmd_t          head;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          full, empty, push, pop, capture;

  logic [7:0]    alu_a_q, alu_b_q, acc_q, rsp_data_q;
  logic [2:0]    alu_sel_q;
  logic          rsp_carry_q, rsp_zero_q;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = fifo_q[rd_ptr_q];
  assign push  = bus.cmd_valid & ~full;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (!empty) state_d = StExec;
      StExec:  state_d = StResp;
      StResp:  if (bus.rsp_ready) state_d = empty ? StIdle : StExec;
      default: state_d = StIdle;
    endcase
  end

  // A pop always loads the ALU operand registers, so pop doubles as the issue strobe.
  always_comb begin
    pop     = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      StIdle:  pop = ~empty;
      StExec:  capture = 1'b1;
      StResp:  pop = bus.rsp_ready & ~empty;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= cmd_t'{sel: bus.cmd_sel, a: bus.cmd_a, b: bus.cmd_b, acc: bus.cmd_acc};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      acc_q       <= '0;
      rsp_data_q  <= '0;
      rsp_carry_q <= 1'b0;
      rsp_zero_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);

      // acc_q is read before any same-edge clear or capture takes effect.
      if (pop) begin
        alu_a_q   <= head.acc ? acc_q : head.a;
        alu_b_q   <= head.b;
        alu_sel_q <= head.sel;
      end

      if (capture) begin
        rsp_data_q  <= bus.alu_res;
        rsp_carry_q <= bus.alu_cy;
        rsp_zero_q  <= (bus.alu_res == 8'h00);
      end

      if (bus.acc_clr) begin
        acc_q <= '0;
      end else if (capture) begin
        acc_q <= bus.alu_res;
      end
    end
  end

  assign bus.cmd_ready = ~full;
  assign bus.rsp_valid = (state_q == StResp);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_carry = rsp_carry_q;
  assign bus.rsp_zero  = rsp_zero_q;
  assign bus.acc_out   = acc_q;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_sel   = alu_sel_q;
  assign bus.busy      = (state_q != StIdle) | ~empty;
  assign bus.cmd_count = count_q;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: directed timing checks plus a randomized run scored
// against an in-order result queue built from the command stream.
module tb_alu_cmd_sequencer;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_cmd_sequencer_if #(.DEPTH(DEPTH)) bus ();

  alu_cmd_sequencer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural alu_8bit: {carry, result}; 000 = ADD.
  function automatic logic [8:0] alu_ref(input logic [2:0] sel, input logic [7:0] a,
                                         input logic [7:0] b);
    case (sel)
      3'b000:  return {1'b0, a} + {1'b0, b};
      3'b001:  return {1'b0, a} - {1'b0, b};
      3'b010:  return {1'b0, a & b};
      3'b011:  return {1'b0, a | b};
      3'b100:  return {1'b0, a ^ b};
      3'b101:  return {1'b0, ~a};
      3'b110:  return {a[7], a[6:0], 1'b0};
      default: return {a[0], 1'b0, a[7:1]};
    endcase
  endfunction

  assign {bus.alu_cy, bus.alu_res} = alu_ref(bus.alu_sel, bus.alu_a, bus.alu_b);

  int          tests = 0;
  int          fails = 0;
  int          cyc   = 0;
  logic [8:0]  exp_q [$];
  int          hs_cyc [$];
  logic [7:0]  m_acc;
  bit          rand_ready = 1'b0;
  bit          last_push  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock with scoreboarding: accepted commands extend the expected result stream.
  task automatic cycle();
    logic       psh, hs;
    logic [7:0] a_eff;
    logic [8:0] r;
    if (rand_ready) bus.rsp_ready = 1'($urandom_range(0, 1));
    psh = bus.cmd_valid & bus.cmd_ready;
    hs  = bus.rsp_valid & bus.rsp_ready;
    tick();
    cyc++;
    last_push = psh;
    if (psh) begin
      a_eff = bus.cmd_acc ? m_acc : bus.cmd_a;
      r     = alu_ref(bus.cmd_sel, a_eff, bus.cmd_b);
      m_acc = r[7:0];
      exp_q.push_back(r);
    end
    if (hs) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      hs_cyc.push_back(cyc);
    end
    check("busy", 32'(bus.busy), 32'(exp_q.size() != 0));
    if (bus.rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("stale_rsp", 32'(bus.rsp_valid), 32'd0);
      end else begin
        check("rsp_data", 32'(bus.rsp_data), 32'(exp_q[0][7:0]));
        check("rsp_carry", 32'(bus.rsp_carry), 32'(exp_q[0][8]));
        check("rsp_zero", 32'(bus.rsp_zero), 32'(exp_q[0][7:0] == 8'h00));
      end
    end
  endtask

  task automatic offer(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b,
                       input logic use_acc);
    int n = 0;
    bus.cmd_sel   = sel;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_acc   = use_acc;
    bus.cmd_valid = 1'b1;
    last_push     = 1'b0;
    while (!last_push && n < 100) begin
      cycle();
      n++;
    end
    check("push_accepted", 32'(last_push), 32'd1);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic offer_rand();
    offer(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
  endtask

  task automatic drain();
    int n = 0;
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    while (exp_q.size() != 0 && n < 200) begin
      cycle();
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Directed single command with rsp_ready high: push E0, issue E1, result after E2.
  task automatic exec_cmd(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b,
                          input logic use_acc, input logic clr, input logic [7:0] exp_a,
                          input logic [7:0] exp_res, input logic exp_cy,
                          input logic [7:0] exp_acc);
    bus.cmd_sel   = sel;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_acc   = use_acc;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    check("e0_count", 32'(bus.cmd_count), 32'd1);
    check("e0_busy", 32'(bus.busy), 32'd1);
    check("e0_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    tick();
    check("e1_count", 32'(bus.cmd_count), 32'd0);
    check("e1_alu_a", 32'(bus.alu_a), 32'(exp_a));
    check("e1_alu_b", 32'(bus.alu_b), 32'(b));
    check("e1_alu_sel", 32'(bus.alu_sel), 32'(sel));
    check("e1_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    bus.acc_clr = clr;
    tick();
    bus.acc_clr = 1'b0;
    check("e2_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("e2_rsp_data", 32'(bus.rsp_data), 32'(exp_res));
    check("e2_rsp_carry", 32'(bus.rsp_carry), 32'(exp_cy));
    check("e2_rsp_zero", 32'(bus.rsp_zero), 32'(exp_res == 8'h00));
    check("e2_acc_out", 32'(bus.acc_out), 32'(exp_acc));
    tick();
    check("e3_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("e3_busy", 32'(bus.busy), 32'd0);
    check("e3_alu_a_hold", 32'(bus.alu_a), 32'(exp_a));
    check("e3_acc_out", 32'(bus.acc_out), 32'(exp_acc));
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_sel   = 3'b000;
    bus.cmd_a     = 8'h12;
    bus.cmd_b     = 8'h34;
    bus.cmd_acc   = 1'b0;
    bus.rsp_ready = 1'b1;
    bus.acc_clr   = 1'b0;
    m_acc         = 8'h00;

    tick();
    tick();
    check("rst_count", 32'(bus.cmd_count), 32'd0);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    rst_n         = 1'b1;
    bus.cmd_valid = 1'b0;
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_acc_out", 32'(bus.acc_out), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_alu_a", 32'(bus.alu_a), 32'd0);
    tick();
    check("idle_count", 32'(bus.cmd_count), 32'd0);
    check("idle_busy", 32'(bus.busy), 32'd0);

    exec_cmd(3'b000, 8'h6F, 8'h6F, 1'b0, 1'b0, 8'h6F, 8'hDE, 1'b0, 8'hDE);
    exec_cmd(3'b000, 8'hFF, 8'h01, 1'b0, 1'b0, 8'hFF, 8'h00, 1'b1, 8'h00);
    exec_cmd(3'b000, 8'hF0, 8'h20, 1'b0, 1'b0, 8'hF0, 8'h10, 1'b1, 8'h10);
    // Operand A comes from the accumulator (0x10); clear lands on the capture edge.
    exec_cmd(3'b000, 8'h77, 8'h05, 1'b1, 1'b1, 8'h10, 8'h15, 1'b0, 8'h00);

    // Backpressure: one in flight plus DEPTH queued, then the extra command must wait.
    m_acc         = 8'h00;
    bus.rsp_ready = 1'b0;
    hs_cyc.delete();
    for (int i = 0; i < DEPTH + 1; i++) offer_rand();
    check("bp_full_ready", 32'(bus.cmd_ready), 32'd0);
    check("bp_full_count", 32'(bus.cmd_count), 32'(DEPTH));
    bus.cmd_sel   = 3'b000;
    bus.cmd_a     = 8'h81;
    bus.cmd_b     = 8'h90;
    bus.cmd_acc   = 1'b1;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("bp_stall_count", 32'(bus.cmd_count), 32'(DEPTH));
      check("bp_stall_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    end
    bus.rsp_ready = 1'b1;
    begin
      int n = 0;
      last_push = 1'b0;
      while (!last_push && n < 50) begin
        cycle();
        n++;
      end
    end
    check("bp_late_push", 32'(last_push), 32'd1);
    drain();
    check("bp_rsp_total", 32'(hs_cyc.size()), 32'(DEPTH + 2));
    for (int i = 1; i < hs_cyc.size(); i++) begin
      check("bp_rsp_spacing", 32'(hs_cyc[i] - hs_cyc[i-1]), 32'd2);
    end

    // Randomized traffic with random response backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      int gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) cycle();
      offer_rand();
    end
    rand_ready = 1'b0;
    drain();
    check("rand_acc_out", 32'(bus.acc_out), 32'(m_acc));
    check("rand_busy", 32'(bus.busy), 32'd0);

    // Reset while the second command executes with two more queued.
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) offer_rand();
    bus.rsp_ready = 1'b1;
    cycle();
    check("mid_queued", 32'(bus.cmd_count), 32'd2);
    check("mid_exec_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    rst_n = 1'b0;
    tick();
    exp_q.delete();
    m_acc = 8'h00;
    check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("mid_rst_count", 32'(bus.cmd_count), 32'd0);
    check("mid_rst_acc", 32'(bus.acc_out), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_ready", 32'(bus.cmd_ready), 32'd1);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      check("post_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
